// File: rtl/dht11_pkg.sv
// Shared types and frame constants for the DHT11 single-wire sequencer.
// Used by dht11_ctrl and dht11_us_tick.
package dht11_pkg;

  localparam int DATA_BITS = 40;
  localparam int BYTE_W    = 8;

  typedef enum logic [3:0] {
    IDLE,
    START_LOW,
    RELEASE,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK,
    COOLDOWN
  } state_t;

  // Sum of the four payload bytes, modulo 256, must equal the trailing byte.
  function automatic logic checksum_ok(input logic [DATA_BITS-1:0] frame);
    logic [BYTE_W-1:0] sum;
    sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return (sum == frame[7:0]);
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Prescaler producing a single-cycle pulse once per microsecond.
// CLK_FREQ_HZ / 1_000_000 must be at least 2.
module dht11_us_tick
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int CW  = $clog2(DIV);

  logic [CW-1:0] cnt_reg;
  logic          tick_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (cnt_reg == CW'(DIV - 1)) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b1;
    end else begin
      cnt_reg  <= cnt_reg + 1'b1;
      tick_reg <= 1'b0;
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/dht11_ctrl.sv
// DHT11 bus sequencer: start pulse, response timing, 40-bit pulse-width decode,
// checksum and result latch. Optional macro DHT11_AUTO_POLL_EN adds a periodic self-start.
module dht11_ctrl
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 200,
  parameter int BIT_THRESH_US = 40,
  parameter int COOLDOWN_US   = 1_000_000
`ifdef DHT11_AUTO_POLL_EN
  ,
  parameter int POLL_MS       = 2000
`endif
) (
  input  logic       s00_axi_aclk,
  input  logic       s00_axi_aresetn,
  input  logic       start,
  input  logic       dht_i,
  output logic       dht_oe,
  output logic       busy,
  output logic       data_valid,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] tmp_int,
  output logic [7:0] tmp_dec,
  output logic       chk_err,
  output logic       tmo_err
);

  localparam logic [19:0] START_LOW_T = 20'(START_LOW_US);
  localparam logic [19:0] TIMEOUT_T   = 20'(TIMEOUT_US);
  localparam logic [19:0] COOLDOWN_T  = 20'(COOLDOWN_US);
  localparam logic [20:0] THRESH_T    = 21'(BIT_THRESH_US);

  state_t                 state_reg, state_next;
  logic                   dht_meta_reg, dht_sync_reg;
  logic                   rel_high_reg;
  logic                   tick;
  logic [19:0]            phase_cnt_reg;
  logic [20:0]            phase_now;
  logic [5:0]             bit_cnt_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   dht_oe_reg, busy_reg, data_valid_reg;
  logic                   chk_err_reg, tmo_err_reg;
  logic [BYTE_W-1:0]      hum_int_reg, hum_dec_reg, tmp_int_reg, tmp_dec_reg;

  logic start_req, accept, shift_en, bit_val, latch_en, chk_fail, tmo_hit, in_wait;

  dht11_us_tick #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_tick (
    .clk  (s00_axi_aclk),
    .rst_n(s00_axi_aresetn),
    .tick (tick)
  );

`ifdef DHT11_AUTO_POLL_EN
  localparam int MS_W = $clog2(POLL_MS + 1);

  logic [9:0]      us_in_ms_reg;
  logic [MS_W-1:0] ms_cnt_reg;
  logic            poll_due;

  assign poll_due = (ms_cnt_reg >= MS_W'(POLL_MS));

  // Holds at expiry until IDLE accepts it, so a poll that lands mid-read is served next.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      us_in_ms_reg <= '0;
      ms_cnt_reg   <= '0;
    end else if (accept) begin
      us_in_ms_reg <= '0;
      ms_cnt_reg   <= '0;
    end else if (tick) begin
      if (us_in_ms_reg == 10'd999) begin
        us_in_ms_reg <= '0;
        if (!poll_due) ms_cnt_reg <= ms_cnt_reg + 1'b1;
      end else begin
        us_in_ms_reg <= us_in_ms_reg + 1'b1;
      end
    end
  end

  assign start_req = start | poll_due;
`else
  assign start_req = start;
`endif

  // Include the tick of the final cycle so the measured width is exact in whole µs.
  assign phase_now = {1'b0, phase_cnt_reg} + 21'(tick);
  assign in_wait   = state_reg inside {RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH};

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    shift_en   = 1'b0;
    latch_en   = 1'b0;
    chk_fail   = 1'b0;
    tmo_hit    = 1'b0;
    bit_val    = (phase_now > THRESH_T);
    case (state_reg)
      IDLE: begin
        if (start_req) begin
          state_next = START_LOW;
          accept     = 1'b1;
        end
      end
      START_LOW: if (phase_cnt_reg >= START_LOW_T) state_next = RELEASE;
      // The synchronizer still shows our own low drive for a few cycles after
      // release; wait until the pull-up is seen before accepting the sensor's low.
      RELEASE:   if (rel_high_reg && !dht_sync_reg) state_next = RESP_LOW;
      RESP_LOW:  if (dht_sync_reg)  state_next = RESP_HIGH;
      RESP_HIGH: if (!dht_sync_reg) state_next = BIT_LOW;
      BIT_LOW:   if (dht_sync_reg)  state_next = BIT_HIGH;
      BIT_HIGH: begin
        if (!dht_sync_reg) begin
          shift_en   = 1'b1;
          state_next = (bit_cnt_reg == 6'(DATA_BITS - 1)) ? CHECK : BIT_LOW;
        end
      end
      CHECK: begin
        state_next = COOLDOWN;
        if (checksum_ok(shift_reg)) latch_en = 1'b1;
        else                        chk_fail = 1'b1;
      end
      COOLDOWN:  if (phase_cnt_reg >= COOLDOWN_T) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (in_wait && (phase_cnt_reg >= TIMEOUT_T)) begin
      state_next = COOLDOWN;
      tmo_hit    = 1'b1;
      shift_en   = 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_reg     <= IDLE;
      dht_meta_reg  <= 1'b1;
      dht_sync_reg  <= 1'b1;
      rel_high_reg  <= 1'b0;
      phase_cnt_reg <= '0;
      dht_oe_reg    <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      dht_meta_reg <= dht_i;
      dht_sync_reg <= dht_meta_reg;
      rel_high_reg <= (state_reg == RELEASE) && (rel_high_reg || dht_sync_reg);
      if (state_next != state_reg)
        phase_cnt_reg <= '0;
      else if (tick && (phase_cnt_reg != '1))
        phase_cnt_reg <= phase_cnt_reg + 1'b1;
      dht_oe_reg <= (state_next == START_LOW);
      busy_reg   <= (state_next != IDLE);
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      data_valid_reg <= 1'b0;
      chk_err_reg    <= 1'b0;
      tmo_err_reg    <= 1'b0;
      hum_int_reg    <= '0;
      hum_dec_reg    <= '0;
      tmp_int_reg    <= '0;
      tmp_dec_reg    <= '0;
    end else begin
      data_valid_reg <= latch_en;
      if (accept) begin
        bit_cnt_reg <= '0;
        shift_reg   <= '0;
        chk_err_reg <= 1'b0;
        tmo_err_reg <= 1'b0;
      end
      if (shift_en) begin
        shift_reg   <= {shift_reg[DATA_BITS-2:0], bit_val};
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
      if (chk_fail) chk_err_reg <= 1'b1;
      if (tmo_hit)  tmo_err_reg <= 1'b1;
      if (latch_en) begin
        hum_int_reg <= shift_reg[39:32];
        hum_dec_reg <= shift_reg[31:24];
        tmp_int_reg <= shift_reg[23:16];
        tmp_dec_reg <= shift_reg[15:8];
      end
    end
  end

  assign dht_oe     = dht_oe_reg;
  assign busy       = busy_reg;
  assign data_valid = data_valid_reg;
  assign chk_err    = chk_err_reg;
  assign tmo_err    = tmo_err_reg;
  assign hum_int    = hum_int_reg;
  assign hum_dec    = hum_dec_reg;
  assign tmp_int    = tmp_int_reg;
  assign tmp_dec    = tmp_dec_reg;

endmodule

// File: tb/tb_dht11_ctrl.sv
// Self-checking bench for dht11_ctrl with an open-drain DHT11 sensor model
// (2 MHz clock, scaled start/cooldown times).
module tb_dht11_ctrl;

  localparam int CLK_HZ = 2_000_000;
  localparam int CPU    = 2;  // clock cycles per microsecond

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dht_i;
  logic       dht_oe, busy, data_valid, chk_err, tmo_err;
  logic [7:0] hum_int, hum_dec, tmp_int, tmp_dec;

  always #5 clk = ~clk;

  dht11_ctrl #(
    .CLK_FREQ_HZ  (CLK_HZ),
    .START_LOW_US (50),
    .TIMEOUT_US   (200),
    .BIT_THRESH_US(40),
    .COOLDOWN_US  (100)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .start          (start),
    .dht_i          (dht_i),
    .dht_oe         (dht_oe),
    .busy           (busy),
    .data_valid     (data_valid),
    .hum_int        (hum_int),
    .hum_dec        (hum_dec),
    .tmp_int        (tmp_int),
    .tmp_dec        (tmp_dec),
    .chk_err        (chk_err),
    .tmo_err        (tmo_err)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- open-drain sensor model ----------------
  logic        sensor_low = 1'b0;
  logic [39:0] sens_frame = '0;
  int          sens_w0 = 25, sens_w1 = 60;
  bit          sens_on = 1'b0, sens_active = 1'b0, sens_high = 1'b0;
  int          sens_bit = -1;
  int          frames_on_wire = 0;

  assign dht_i = ((dht_oe === 1'b1) || sensor_low) ? 1'b0 : 1'b1;

  task automatic wait_us(input int n);
    repeat (n * CPU) @(negedge clk);
  endtask

  always begin
    @(negedge dht_oe);
    frames_on_wire++;
    if (sens_on) begin
      sens_active = 1'b1;
      wait_us(20); sensor_low = 1'b1;
      wait_us(80); sensor_low = 1'b0;
      wait_us(80);
      for (int i = 39; i >= 0; i--) begin
        sens_bit = i;
        sensor_low = 1'b1; wait_us(15);
        sensor_low = 1'b0; sens_high = 1'b1;
        wait_us(sens_frame[i] ? sens_w1 : sens_w0);
        sens_high = 1'b0;
      end
      sensor_low = 1'b1; wait_us(15);
      sensor_low = 1'b0;
      sens_bit = -1;
      sens_active = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] sb_q[$];
  logic [31:0] sb_exp;
  int          dv_count = 0, dv_cyc = 0, tmo_cyc = 0;
  logic        tmo_prev = 1'b0;

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      dv_count++;
      dv_cyc = cyc;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected_valid: got data_valid=1 want no pulse (data %0h)",
                 {hum_int, hum_dec, tmp_int, tmp_dec});
      end else begin
        sb_exp = sb_q.pop_front();
        check("sb_data", {hum_int, hum_dec, tmp_int, tmp_dec}, sb_exp);
      end
    end
    if (tmo_err === 1'b1 && tmo_prev !== 1'b1) tmo_cyc = cyc;
    tmo_prev = tmo_err;
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [39:0] frame;
    int          w0;
    int          w1;
    bit          sensor_on;
    bit          exp_valid;
    bit          exp_chk;
    bit          exp_tmo;
    logic [7:0]  exp_hi, exp_hd, exp_ti, exp_td;
  } vec_t;

  vec_t vecs[5];

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_read(input vec_t v, input string tag);
    int dv0, fr0, n, rel_c, busy_c;
    sens_frame = v.frame; sens_w0 = v.w0; sens_w1 = v.w1; sens_on = v.sensor_on;
    dv0 = dv_count; fr0 = frames_on_wire; tmo_cyc = 0;
    if (v.exp_valid) sb_q.push_back({v.exp_hi, v.exp_hd, v.exp_ti, v.exp_td});
    pulse_start();
    check({tag, "_oe_on"}, dht_oe, 1);
    check({tag, "_busy_on"}, busy, 1);
    n = 0;
    while (dht_oe === 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check_rng({tag, "_start_width"}, n, 98, 104);
    rel_c = cyc;
    n = 0;
    while (busy === 1'b1 && n < 20000) begin @(negedge clk); n++; end
    busy_c = cyc;
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_chk_err"}, chk_err, v.exp_chk);
    check({tag, "_tmo_err"}, tmo_err, v.exp_tmo);
    check({tag, "_data"}, {hum_int, hum_dec, tmp_int, tmp_dec},
          {v.exp_hi, v.exp_hd, v.exp_ti, v.exp_td});
    check({tag, "_dv_pulses"}, dv_count - dv0, v.exp_valid ? 1 : 0);
    check({tag, "_oe_idle"}, dht_oe, 0);
    check({tag, "_frames"}, frames_on_wire - fr0, 1);
    if (v.exp_valid) check_rng({tag, "_cooldown"}, busy_c - dv_cyc, 196, 206);
    if (v.exp_tmo)   check_rng({tag, "_tmo_latency"}, tmo_cyc - rel_c, 396, 408);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish by 3 ms want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dv0, fr0;
    vecs[0] = '{40'h3700190050, 25, 60, 1'b1, 1'b1, 1'b0, 1'b0, 8'd55, 8'd0, 8'd25, 8'd0};
    vecs[1] = '{40'h3700190051, 25, 60, 1'b1, 1'b0, 1'b1, 1'b0, 8'd55, 8'd0, 8'd25, 8'd0};
    vecs[2] = '{40'h0000000000, 25, 60, 1'b0, 1'b0, 1'b0, 1'b1, 8'd55, 8'd0, 8'd25, 8'd0};
    vecs[3] = '{40'h4100170058, 40, 41, 1'b1, 1'b1, 1'b0, 1'b0, 8'd65, 8'd0, 8'd23, 8'd0};
    vecs[4] = '{40'h2A05160348, 25, 60, 1'b1, 1'b1, 1'b0, 1'b0, 8'd42, 8'd5, 8'd22, 8'd3};

    repeat (3) @(negedge clk);
    check("rst_oe", dht_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_dv", data_valid, 0);
    check("rst_data", {hum_int, hum_dec, tmp_int, tmp_dec}, 0);
    check("rst_errs", {chk_err, tmo_err}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 5; i++) run_read(vecs[i], $sformatf("vec%0d", i));

    // Starts mid-frame and mid-cooldown must be dropped, not queued.
    sens_frame = vecs[0].frame; sens_w0 = 25; sens_w1 = 60; sens_on = 1'b1;
    dv0 = dv_count; fr0 = frames_on_wire;
    sb_q.push_back({8'd55, 8'd0, 8'd25, 8'd0});
    pulse_start();
    n = 0;
    while (!(sens_active && sens_bit == 20) && n < 20000) begin @(negedge clk); n++; end
    check_rng("busy_reach_mid", n, 0, 19999);
    pulse_start();
    n = 0;
    while (dv_count == dv0 && n < 20000) begin @(negedge clk); n++; end
    check_rng("busy_reach_dv", n, 0, 19999);
    repeat (50) @(negedge clk);
    check("busy_mid_cooldown", busy, 1);
    pulse_start();
    n = 0;
    while (busy === 1'b1 && n < 20000) begin @(negedge clk); n++; end
    repeat (300) @(negedge clk);
    check("busy_ignored_idle", busy, 0);
    check("busy_ignored_oe", dht_oe, 0);
    check("busy_frames", frames_on_wire - fr0, 1);
    check("busy_dv_pulses", dv_count - dv0, 1);

    // Reset while driving the start pulse releases the line without a clock edge.
    sens_on = 1'b0;
    pulse_start();
    repeat (10) @(negedge clk);
    check("rst_sl_oe_before", dht_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_sl_oe_async", dht_oe, 0);
    check("rst_sl_busy_async", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset during a bit high phase, then a clean read.
    sens_frame = vecs[0].frame; sens_on = 1'b1;
    pulse_start();
    n = 0;
    while (!(sens_active && sens_bit == 10 && sens_high) && n < 20000) begin @(negedge clk); n++; end
    check_rng("rst_bh_reach", n, 0, 19999);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_bh_oe", dht_oe, 0);
    check("rst_bh_busy", busy, 0);
    check("rst_bh_data", {hum_int, hum_dec, tmp_int, tmp_dec}, 0);
    check("rst_bh_errs", {chk_err, tmo_err, data_valid}, 0);
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    while (sens_active && n < 20000) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    run_read(vecs[0], "post_rst");

    repeat (10) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
